sync_fifo_ctrl: RTL and testbench
=================================

// Module: sync_fifo_ctrl
// PURPOSE
//  Single-clock FIFO controller that sequences the FIFO's dual-port storage RAM. It:
//  - owns the binary write/read pointers (one extra wrap bit);
//  - qualifies requests and drives the RAM write/read enables;
//  - generates full/empty, fill count and almost-flags;
//  - tracks the RAM's one-cycle registered read latency with rd_valid.
//  Sits between the producer/consumer handshakes and the storage RAM; both sides clock from clk.
// PARAMETERS
//  depth     8  FIFO entries; power of two, >= 2
//  AF_LEVEL  6  almost_full asserts when count >= AF_LEVEL (1..depth)
//  AE_LEVEL  2  almost_empty asserts when count <= AE_LEVEL (0..depth-1)
//  (AW = $clog2(depth); pointer width AW+1)
// PORTS
//  clk           in   1     single clock, all state on posedge
//  rst_n         in   1     asynchronous active-low reset
//  wr_req        in   1     producer write request (data presented to RAM alongside)
//  rd_req        in   1     consumer read request
//  flush         in   1     synchronous clear of FIFO contents
//  bin_w_ptr     out  AW+1  write pointer to RAM; RAM uses low AW bits as address
//  bin_r_ptr     out  AW+1  read pointer to RAM
//  mem_w_en      out  1     RAM write enable = accepted write this cycle
//  mem_r_en      out  1     RAM read enable = accepted read this cycle
//  full          out  1     no free entries
//  empty         out  1     no stored entries
//  count         out  AW+1  stored entries, 0..depth
//  almost_full   out  1     count >= AF_LEVEL
//  almost_empty  out  1     count <= AE_LEVEL
//  rd_valid      out  1     RAM data_out holds the word from the previous cycle's accepted read
//  overflow      out  1     sticky: write request while full (only with FIFO_ERR_FLAGS_EN)
//  underflow     out  1     sticky: read request while empty (only with FIFO_ERR_FLAGS_EN)
// BEHAVIOUR
//  - Reset (rst_n=0, async), cleared immediately:
//    - bin_w_ptr=bin_r_ptr=0, count=0, rd_valid=0, overflow=underflow=0.
//    - Hence empty=1, almost_empty=1, full=0, almost_full=0, mem_w_en=mem_r_en=0.
//  - Accept terms (combinational from registered state):
//    - wr_acc = wr_req & ~full & ~flush; rd_acc = rd_req & ~empty & ~flush.
//    - mem_w_en=wr_acc, mem_r_en=rd_acc.
//  - Pointers: on posedge, wr_acc increments bin_w_ptr and rd_acc increments bin_r_ptr.
//    Both wrap modulo 2^(AW+1), which toggles the wrap bit once per lap.
//  - RAM timing: the RAM samples the current pointer on the edge where the enable is high,
//    so write address = bin_w_ptr before increment and read address = bin_r_ptr before increment.
//  - Flags are pure functions of the registered pointers (no combinational path from requests):
//    - empty = (bin_w_ptr == bin_r_ptr)
//    - full  = (MSBs differ) & (low AW bits equal)
//    - count = bin_w_ptr - bin_r_ptr, mod 2^(AW+1)
//  - Simultaneous accepted read+write: both pointers advance; count and flags are unchanged.
//  - Boundary cases:
//    - Full with wr_req and rd_req: read accepted, write rejected, full drops the next cycle.
//      No same-cycle pass-through.
//    - Empty with both requests: write accepted, read rejected; the data is readable next cycle.
//  - Latency: write-to-not-empty is 1 cycle. rd_valid = rd_acc delayed one cycle, and is 0 after reset or flush.
//  - flush (sync): on posedge, bin_r_ptr <= bin_w_ptr, giving empty=1 and count=0 the next cycle.
//    flush blocks any same-cycle accept, and rd_valid is 0 the following cycle.
//  - Rejected requests have no side effect, except the sticky error flags when enabled.
//  - Reset mid-operation: all state is discarded; RAM contents are don't-care, with no
//    recovery of in-flight data.
// CONFIGURATION
//  FIFO_ERR_FLAGS_EN defined:
//    - overflow sets on posedge when wr_req & full & ~flush; underflow when rd_req & empty & ~flush.
//    - Both hold until rst_n or flush clears them.
//  FIFO_ERR_FLAGS_EN undefined: overflow and underflow are tied to 0; no extra flops.
// TESTING (depth=8, AF_LEVEL=6, AE_LEVEL=2)
//  1. rst_n low mid-traffic -> immediately ptrs=0, empty=1, full=0, count=0, rd_valid=0,
//     almost_empty=1.
//  2. 8 back-to-back wr_req from empty -> mem_w_en on all 8, addresses 0..7, count=8, full=1,
//     bin_w_ptr=4'b1000, almost_full from count=6. A 9th wr_req -> mem_w_en=0, ptr held,
//     overflow=1 if enabled.
//  3. Full, then wr_req=rd_req=1 for 1 cycle -> read accepted only; count=7, full=0;
//     rd_valid=1 the next cycle.
//  4. Simultaneous wr/rd for 20 cycles at count=3 -> count stays 3, both pointers wrap past
//     4'b1111 to 0, no flag change.
//  5. Empty with rd_req=wr_req=1 -> write only, empty=0 the next cycle, rd_valid stays 0;
//     rd_req on empty -> underflow=1 if enabled.
//  6. count=5 with flush=1 and wr_req=1 -> no write; next cycle empty=1, count=0,
//     bin_r_ptr=bin_w_ptr, error flags cleared.

Source files
------------

// File: rtl/sync_fifo_ctrl_if.sv
// ---------------------------------------------------------------------------
// sync_fifo_ctrl_if
// Purpose : bundles the producer/consumer requests and the RAM-facing
//           pointer/enable/status signals of the single-clock FIFO controller.
// Modports:
//   master - request side: drives wr_req, rd_req, flush; observes the rest
//   slave  - the controller: samples the requests, drives pointers, RAM
//            enables, fill count, full/empty/almost flags, rd_valid and the
//            overflow/underflow error flags
// Parameter: depth - FIFO entries (power of two, >= 2); pointers and count
//            are $clog2(depth)+1 bits wide.
// ---------------------------------------------------------------------------
interface sync_fifo_ctrl_if #(
   parameter int depth = 8
);
   localparam int AW = $clog2(depth);

   logic          wr_req;
   logic          rd_req;
   logic          flush;
   logic [AW:0]   bin_w_ptr;
   logic [AW:0]   bin_r_ptr;
   logic          mem_w_en;
   logic          mem_r_en;
   logic          full;
   logic          empty;
   logic [AW:0]   count;
   logic          almost_full;
   logic          almost_empty;
   logic          rd_valid;
   logic          overflow;
   logic          underflow;

   modport master (
      output wr_req, rd_req, flush,
      input  bin_w_ptr, bin_r_ptr, mem_w_en, mem_r_en, full, empty, count,
             almost_full, almost_empty, rd_valid, overflow, underflow
   );

   modport slave (
      input  wr_req, rd_req, flush,
      output bin_w_ptr, bin_r_ptr, mem_w_en, mem_r_en, full, empty, count,
             almost_full, almost_empty, rd_valid, overflow, underflow
   );
endinterface

// File: rtl/sync_fifo_ctrl.sv
// ---------------------------------------------------------------------------
// sync_fifo_ctrl
// Purpose : single-clock FIFO controller sequencing a dual-port storage RAM
//           with one-cycle registered read latency. Owns binary write/read
//           pointers carrying one extra wrap bit, qualifies requests into RAM
//           write/read enables, and derives full/empty, fill count and the
//           almost flags from the registered pointers only.
// Ports   :
//   clk   - single clock, all state on posedge
//   rst_n - asynchronous active-low reset
//   bus   - sync_fifo_ctrl_if.slave: wr_req/rd_req/flush in; bin_w_ptr,
//           bin_r_ptr, mem_w_en, mem_r_en, full, empty, count, almost_full,
//           almost_empty, rd_valid, overflow, underflow out
// Parameters: depth (power of two, >= 2), AF_LEVEL (1..depth),
//             AE_LEVEL (0..depth-1)
// Optional : define FIFO_ERR_FLAGS_EN for sticky overflow/underflow flags;
//            otherwise both are tied low and no flops are built for them.
// ---------------------------------------------------------------------------
module sync_fifo_ctrl #(
   parameter int depth    = 8,
   parameter int AF_LEVEL = 6,
   parameter int AE_LEVEL = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   sync_fifo_ctrl_if.slave   bus
);
   localparam int          AW  = $clog2(depth);
   localparam logic [AW:0] ONE = (AW+1)'(1);

   logic [AW:0] w_ptr;
   logic [AW:0] r_ptr;
   logic [AW:0] fill;
   logic        is_full;
   logic        is_empty;
   logic        wr_acc;
   logic        rd_acc;
   logic        rd_valid_q;

   // Status comes purely from the registered pointers, so no request ever
   // reaches a flag combinationally. Full means one lap apart: wrap bits
   // differ while the address bits match.
   assign is_empty = (w_ptr == r_ptr);
   assign is_full  = (w_ptr[AW] != r_ptr[AW]) && (w_ptr[AW-1:0] == r_ptr[AW-1:0]);
   assign fill     = w_ptr - r_ptr;

   // flush suppresses both accepts so nothing lands in the RAM on the edge
   // that discards the contents.
   assign wr_acc = bus.wr_req && !is_full  && !bus.flush;
   assign rd_acc = bus.rd_req && !is_empty && !bus.flush;

   // Pointer and read-latency tracking. The RAM samples the pre-increment
   // pointer on the same edge, so address and advance line up. flush moves
   // the read pointer onto the write pointer, leaving the FIFO empty.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         w_ptr      <= '0;
         r_ptr      <= '0;
         rd_valid_q <= 1'b0;
      end else begin
         rd_valid_q <= rd_acc;
         if (wr_acc) begin
            w_ptr <= w_ptr + ONE;
         end
         if (bus.flush) begin
            r_ptr <= w_ptr;
         end else if (rd_acc) begin
            r_ptr <= r_ptr + ONE;
         end
      end
   end

`ifdef FIFO_ERR_FLAGS_EN
   logic ovf_q;
   logic unf_q;

   // Sticky error flags: a rejected request against full/empty latches the
   // flag; only reset or flush clears it. flush takes priority over setting.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf_q <= 1'b0;
         unf_q <= 1'b0;
      end else if (bus.flush) begin
         ovf_q <= 1'b0;
         unf_q <= 1'b0;
      end else begin
         if (bus.wr_req && is_full) begin
            ovf_q <= 1'b1;
         end
         if (bus.rd_req && is_empty) begin
            unf_q <= 1'b1;
         end
      end
   end

   assign bus.overflow  = ovf_q;
   assign bus.underflow = unf_q;
`else
   assign bus.overflow  = 1'b0;
   assign bus.underflow = 1'b0;
`endif

   assign bus.bin_w_ptr    = w_ptr;
   assign bus.bin_r_ptr    = r_ptr;
   assign bus.mem_w_en     = wr_acc;
   assign bus.mem_r_en     = rd_acc;
   assign bus.full         = is_full;
   assign bus.empty        = is_empty;
   assign bus.count        = fill;
   assign bus.almost_full  = (fill >= (AW+1)'(AF_LEVEL));
   assign bus.almost_empty = (fill <= (AW+1)'(AE_LEVEL));
   assign bus.rd_valid     = rd_valid_q;

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sync_fifo_ctrl
// Purpose : self-checking bench for sync_fifo_ctrl (depth=8, AF_LEVEL=6,
//           AE_LEVEL=2). A reference model holds the FIFO as a queue of the
//           RAM addresses that were written, plus running totals of accepted
//           writes and reads; every visible output is predicted from it.
//           Directed scenarios are followed by a randomized phase.
// ---------------------------------------------------------------------------
module tb_sync_fifo_ctrl;
   localparam int DEPTH = 8;
   localparam int AF    = 6;
   localparam int AE    = 2;
   localparam int PMOD  = 2 * DEPTH;

   logic clk;
   logic rst_n;

   sync_fifo_ctrl_if #(.depth(DEPTH)) bus ();

   sync_fifo_ctrl #(
      .depth    (DEPTH),
      .AF_LEVEL (AF),
      .AE_LEVEL (AE)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // Free-running clock, 10 time units per period.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_assert;
   int n_fail;

   // Reference model state.
   int wr_total;
   int rd_total;
   int q[$];
   bit prev_racc;
   bit ovf;
   bit unf;

   // Single comparison point: counts the check and reports on mismatch.
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Compare every DUT output against the model; the accept terms are only
   // meaningful with reset released.
   task automatic checkOutput(input bit check_en, input bit w, input bit r, input bit f);
      int sz;
      bit exp_w;
      bit exp_r;
      sz    = q.size();
      exp_w = w && (sz != DEPTH) && !f;
      exp_r = r && (sz != 0) && !f;
      check("bin_w_ptr", 32'(bus.bin_w_ptr), 32'(wr_total % PMOD));
      check("bin_r_ptr", 32'(bus.bin_r_ptr), 32'(rd_total % PMOD));
      check("count", 32'(bus.count), 32'(sz));
      check("full", 32'(bus.full), 32'(sz == DEPTH));
      check("empty", 32'(bus.empty), 32'(sz == 0));
      check("almost_full", 32'(bus.almost_full), 32'(sz >= AF));
      check("almost_empty", 32'(bus.almost_empty), 32'(sz <= AE));
      check("rd_valid", 32'(bus.rd_valid), 32'(prev_racc));
`ifdef FIFO_ERR_FLAGS_EN
      check("overflow", 32'(bus.overflow), 32'(ovf));
      check("underflow", 32'(bus.underflow), 32'(unf));
`else
      check("overflow", 32'(bus.overflow), 32'(0));
      check("underflow", 32'(bus.underflow), 32'(0));
`endif
      if (check_en) begin
         check("mem_w_en", 32'(bus.mem_w_en), 32'(exp_w));
         check("mem_r_en", 32'(bus.mem_r_en), 32'(exp_r));
         if (exp_r) begin
            check("rd_addr", 32'(bus.bin_r_ptr[2:0]), 32'(q[0]));
         end
      end
   endtask

   // One clock cycle: drive at negedge, check just after, then advance the
   // model across the posedge and return at the next negedge.
   task automatic applyStimulus(input bit w, input bit r, input bit f);
      int sz;
      bit wacc;
      bit racc;
      bus.wr_req = w;
      bus.rd_req = r;
      bus.flush  = f;
      #1;
      checkOutput(1'b1, w, r, f);
      sz   = q.size();
      wacc = w && (sz != DEPTH) && !f;
      racc = r && (sz != 0) && !f;
      @(posedge clk);
      if (f) begin
         q.delete();
         rd_total = wr_total;
         ovf = 1'b0;
         unf = 1'b0;
      end else begin
         if (w && sz == DEPTH) ovf = 1'b1;
         if (r && sz == 0)     unf = 1'b1;
         if (racc) begin
            void'(q.pop_front());
            rd_total++;
         end
         if (wacc) begin
            q.push_back(wr_total % DEPTH);
            wr_total++;
         end
      end
      prev_racc = racc;
      @(negedge clk);
   endtask

   // Asynchronous reset: state must clear without any clock edge.
   task automatic doReset();
      rst_n = 1'b0;
      #1;
      wr_total  = 0;
      rd_total  = 0;
      q.delete();
      prev_racc = 1'b0;
      ovf       = 1'b0;
      unf       = 1'b0;
      checkOutput(1'b0, 1'b0, 1'b0, 1'b0);
      bus.wr_req = 1'b0;
      bus.rd_req = 1'b0;
      bus.flush  = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      n_assert   = 0;
      n_fail     = 0;
      rst_n      = 1'b1;
      bus.wr_req = 1'b0;
      bus.rd_req = 1'b0;
      bus.flush  = 1'b0;
      @(negedge clk);
      doReset();

      // Fill from empty: 8 writes, then a 9th is refused.
      for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b0);

      // Full with both requests: only the read goes through.
      applyStimulus(1'b1, 1'b1, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0);

      // Down to 3 entries, then 20 cycles of concurrent traffic so both
      // pointers wrap.
      for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 20; i++) applyStimulus(1'b1, 1'b1, 1'b0);

      // Drain, then both requests on empty, then a read on empty.
      for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 1'b0);
      applyStimulus(1'b1, 1'b1, 1'b0);
      applyStimulus(1'b0, 1'b1, 1'b0);
      applyStimulus(1'b0, 1'b1, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0);

      // Build 5 entries and flush with a concurrent write.
      for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b1);
      applyStimulus(1'b0, 1'b0, 1'b0);

      // Randomized traffic with an occasional flush and a mid-run reset.
      for (int i = 0; i < 300; i++) begin
         if (i == 150) begin
            bus.wr_req = 1'b1;
            bus.rd_req = 1'b1;
            doReset();
         end
         applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       ($urandom_range(0, 15) == 0));
      end

      // Reset while traffic is live at a full FIFO.
      for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b0, 1'b0);
      bus.wr_req = 1'b1;
      bus.rd_req = 1'b1;
      doReset();
      applyStimulus(1'b0, 1'b0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
